// File: rtl/fp_to_int.sv
// Iterative float-to-signed-integer converter; alignment shifts one bit per clock.
// Define FP2INT_ROUND_NEAREST_EN for round-half-to-even instead of truncation toward zero.
module fp_to_int #(
    parameter int N    = 32,
    parameter int OUTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUTW-1:0] out_data,
    output logic            out_invalid,
    output logic            out_overflow,
    output logic            out_inexact
);
    localparam int EXPW  = N / 4;
    localparam int FRACW = N - EXPW - 1;
    localparam int BIAS  = 2 ** (EXPW - 1) - 1;
    localparam int MAGW  = ((OUTW > FRACW + 1) ? OUTW : FRACW + 1) + 1;
    localparam int CW    = $clog2(MAGW + 2) + 1;
    localparam logic [MAGW-1:0] MAXMAG = {{(MAGW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic [MAGW-1:0] MINMAG = MAXMAG + MAGW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

    state_t          r_state, w_nextState;
    logic [MAGW-1:0] r_mag, w_initMag, w_rmag;
    logic [CW-1:0]   r_cnt, w_k;
    logic            r_sign, r_left, r_guard, r_sticky, r_inv, r_ovf, r_inx;
    logic            w_left, w_inv, w_ovf, w_inx, w_round, w_carryOvf;
    logic            w_sign;
    logic [EXPW-1:0] w_exp;
    logic [FRACW-1:0] w_frac;
    logic [FRACW:0]  w_mant;
    logic [OUTW-1:0] w_res;
    int              w_e;

    assign w_sign    = in_data[N-1];
    assign w_exp     = in_data[N-2 -: EXPW];
    assign w_frac    = in_data[FRACW-1:0];
    assign w_mant    = {1'b1, w_frac};
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // Saturated magnitudes rely on the FINISH negation: MINMAG negates to MIN.
    always_comb begin
        w_e       = int'(w_exp) - BIAS;
        w_initMag = '0;
        w_k       = '0;
        w_left    = 1'b0;
        w_inv     = 1'b0;
        w_ovf     = 1'b0;
        w_inx     = 1'b0;
        if (w_exp == '1) begin
            if (w_frac != '0) begin
                w_inv = 1'b1;
            end else begin
                w_ovf     = 1'b1;
                w_initMag = w_sign ? MINMAG : MAXMAG;
            end
        end else if (w_exp == '0) begin
            w_inx = (w_frac != '0);
        end else if (w_e < 0) begin
`ifdef FP2INT_ROUND_NEAREST_EN
            if (w_e == -1) begin
                w_initMag = MAGW'(w_mant);
                w_k       = CW'(FRACW + 1);
            end else begin
                w_inx = 1'b1;
            end
`else
            w_inx = 1'b1;
`endif
        end else if (w_e > OUTW - 1 || (w_e == OUTW - 1 && !(w_sign && w_frac == '0))) begin
            w_ovf     = 1'b1;
            w_initMag = w_sign ? MINMAG : MAXMAG;
        end else if (w_e == OUTW - 1) begin
            w_initMag = MINMAG;
        end else if (w_e >= FRACW) begin
            w_initMag = MAGW'(w_mant);
            w_k       = CW'(w_e - FRACW);
            w_left    = 1'b1;
        end else begin
            w_initMag = MAGW'(w_mant);
            w_k       = CW'(FRACW - w_e);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = (w_k != '0) ? SHIFT : FINISH;
            SHIFT:   if (r_cnt == CW'(1)) w_nextState = FINISH;
            FINISH:  w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_round = 1'b0;
`ifdef FP2INT_ROUND_NEAREST_EN
        w_round = r_guard & (r_sticky | r_mag[0]);
`endif
        w_rmag     = r_mag + MAGW'(w_round);
        w_carryOvf = w_round & (w_rmag > MAXMAG);
        if (w_carryOvf)
            w_res = r_sign ? OUTW'(MINMAG) : OUTW'(MAXMAG);
        else
            w_res = r_sign ? OUTW'(~w_rmag + MAGW'(1)) : OUTW'(w_rmag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mag        <= '0;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_left       <= 1'b0;
            r_guard      <= 1'b0;
            r_sticky     <= 1'b0;
            r_inv        <= 1'b0;
            r_ovf        <= 1'b0;
            r_inx        <= 1'b0;
            out_data     <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign   <= w_sign;
                        r_mag    <= w_initMag;
                        r_cnt    <= w_k;
                        r_left   <= w_left;
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
                        r_inv    <= w_inv;
                        r_ovf    <= w_ovf;
                        r_inx    <= w_inx;
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_left) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        r_mag    <= r_mag >> 1;
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                end
                FINISH: begin
                    out_data     <= w_res;
                    out_invalid  <= r_inv;
                    out_overflow <= r_ovf | w_carryOvf;
                    out_inexact  <= r_inx | r_guard | r_sticky;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: scoreboard queue of expected results, one task per scenario.
module tb_fp_to_int;
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_invalid, out_overflow, out_inexact;

    int   passCount = 0;
    int   checkCount = 0;
    exp_t sbQ[$];

    fp_to_int #(.N(32), .OUTW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_invalid(out_invalid), .out_overflow(out_overflow), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    // Independent reference: integer arithmetic on the decoded float; flags are {invalid, overflow, inexact}.
    function automatic exp_t model(input logic [31:0] x);
        exp_t        r;
        logic        s = x[31];
        int          ex = int'(x[30:23]);
        logic [22:0] f = x[22:0];
        int          e = ex - 127;
        longint      mant = longint'({1'b1, f});
        longint      mag, rem, half;
        int          sh;
        bit          rn = 1'b0;
`ifdef FP2INT_ROUND_NEAREST_EN
        rn = 1'b1;
`endif
        r.data = '0; r.flags = '0; r.lat = 2;
        if (ex == 255) begin
            if (f != 0) r.flags[2] = 1'b1;
            else begin r.flags[1] = 1'b1; r.data = s ? 32'h80000000 : 32'h7FFFFFFF; end
        end else if (ex == 0) begin
            r.flags[0] = (f != 0);
        end else if (e < -1 || (e == -1 && !rn)) begin
            r.flags[0] = 1'b1;
        end else if (e >= 31) begin
            if (e == 31 && s && f == 0) r.data = 32'h80000000;
            else begin r.flags[1] = 1'b1; r.data = s ? 32'h80000000 : 32'h7FFFFFFF; end
        end else begin
            if (e >= 23) begin
                mag = mant << (e - 23);
                r.lat = e - 23 + 2;
            end else begin
                sh   = 23 - e;
                mag  = mant >> sh;
                rem  = mant & ((64'sd1 << sh) - 1);
                half = 64'sd1 << (sh - 1);
                r.flags[0] = (rem != 0);
                if (rn && (rem > half || (rem == half && mag[0]))) mag++;
                r.lat = sh + 2;
            end
            if (mag > 64'sh7FFFFFFF) begin
                r.flags[1] = 1'b1;
                r.data = s ? 32'h80000000 : 32'h7FFFFFFF;
            end else begin
                r.data = s ? 32'(-mag) : 32'(mag);
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [31:0] x, input exp_t e, output bit accepted);
        int waitCnt = 0;
        sbQ.push_back(e);
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        accepted = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge; lat counts edges up to the first one that sees out_valid.
    task automatic waitOutput(output int lat, output bit timedOut);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 100);
        timedOut = !out_valid;
        lat = cyc;
    endtask

    task automatic takeOutput();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); else passCount++;
        checkCount++;
        if (out_data !== 32'h0) $display("[TB] FAIL reset out_data: got %h expected 0", out_data); else passCount++;
        checkCount++;
        if ({out_invalid, out_overflow, out_inexact} !== 3'b000)
            $display("[TB] FAIL reset flags: got %b expected 000", {out_invalid, out_overflow, out_inexact});
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL post-reset in_ready: got %b expected 1", in_ready); else passCount++;
    endtask

    task automatic test_directed();
        logic [31:0] dirIn [6] = '{32'h3F800000, 32'h4B800000, 32'hC0200000, 32'h4F32D05E, 32'hCF000000, 32'h7FC00000};
        logic [31:0] dirOut[6] = '{32'd1, 32'd16777216, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000, 32'h0};
        logic [2:0]  dirFlg[6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b100};
        int          dirLat[6] = '{25, 3, 24, 2, 2, 2};
        exp_t e;
        bit   acc, to;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            e.data = dirOut[i]; e.flags = dirFlg[i]; e.lat = dirLat[i];
            applyStimulus(dirIn[i], e, acc);
            waitOutput(lat, to);
            e = sbQ.pop_front();
            checkCount++;
            if (!acc || to) $display("[TB] FAIL directed[%0d] handshake: accepted=%b timedOut=%b expected 1/0", i, acc, to); else passCount++;
            checkCount++;
            if (out_data !== e.data) $display("[TB] FAIL directed[%0d] data: got %h expected %h", i, out_data, e.data); else passCount++;
            checkCount++;
            if ({out_invalid, out_overflow, out_inexact} !== e.flags)
                $display("[TB] FAIL directed[%0d] flags: got %b expected %b", i, {out_invalid, out_overflow, out_inexact}, e.flags);
            else passCount++;
            checkCount++;
            if (lat != e.lat) $display("[TB] FAIL directed[%0d] latency: got %0d expected %0d", i, lat, e.lat); else passCount++;
            checkCount++;
            if (in_ready !== 1'b0) $display("[TB] FAIL directed[%0d] busy in_ready: got %b expected 0", i, in_ready); else passCount++;
            takeOutput();
        end
    endtask

    task automatic test_random();
        logic [31:0] x;
        exp_t e;
        bit   acc, to;
        int   lat;
        for (int i = 0; i < 24; i++) begin
            x[31]    = 1'($urandom_range(0, 1));
            x[30:23] = 8'($urandom_range(100, 160));
            x[22:0]  = 23'($urandom);
            case (i)
                0: x = 32'h3F400000;
                1: x = 32'h3FC00000;
                2: x = 32'h40200000;
                3: x = 32'h00400000;
                4: x = 32'hFF800000;
                5: x = 32'h4B000001;
                default: ;
            endcase
            applyStimulus(x, model(x), acc);
            waitOutput(lat, to);
            e = sbQ.pop_front();
            checkCount++;
            if (!acc || to) $display("[TB] FAIL random[%0d] %h handshake: accepted=%b timedOut=%b expected 1/0", i, x, acc, to); else passCount++;
            checkCount++;
            if (out_data !== e.data) $display("[TB] FAIL random[%0d] %h data: got %h expected %h", i, x, out_data, e.data); else passCount++;
            checkCount++;
            if ({out_invalid, out_overflow, out_inexact} !== e.flags)
                $display("[TB] FAIL random[%0d] %h flags: got %b expected %b", i, x, {out_invalid, out_overflow, out_inexact}, e.flags);
            else passCount++;
            checkCount++;
            if (lat != e.lat) $display("[TB] FAIL random[%0d] %h latency: got %0d expected %0d", i, x, lat, e.lat); else passCount++;
            takeOutput();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   acc, to;
        int   lat;
        applyStimulus(32'hC0200000, model(32'hC0200000), acc);
        waitOutput(lat, to);
        e = sbQ.pop_front();
        checkCount++;
        if (!acc || to) $display("[TB] FAIL backpressure handshake: accepted=%b timedOut=%b expected 1/0", acc, to); else passCount++;
        for (int c = 0; c < 5; c++) begin
            checkCount++;
            if (out_valid !== 1'b1) $display("[TB] FAIL backpressure[%0d] out_valid: got %b expected 1", c, out_valid); else passCount++;
            checkCount++;
            if (out_data !== e.data) $display("[TB] FAIL backpressure[%0d] data: got %h expected %h", c, out_data, e.data); else passCount++;
            checkCount++;
            if ({out_invalid, out_overflow, out_inexact} !== e.flags)
                $display("[TB] FAIL backpressure[%0d] flags: got %b expected %b", c, {out_invalid, out_overflow, out_inexact}, e.flags);
            else passCount++;
            checkCount++;
            if (in_ready !== 1'b0) $display("[TB] FAIL backpressure[%0d] in_ready: got %b expected 0", c, in_ready); else passCount++;
            @(negedge clk);
        end
        takeOutput();
        @(negedge clk);
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL after handshake out_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL after handshake in_ready: got %b expected 1", in_ready); else passCount++;
    endtask

    task automatic test_reset_midshift();
        exp_t e;
        bit   acc, to;
        int   lat;
        applyStimulus(32'h3F800000, model(32'h3F800000), acc);
        repeat (5) @(negedge clk);
        checkCount++;
        if (in_ready !== 1'b0) $display("[TB] FAIL midshift busy in_ready: got %b expected 0", in_ready); else passCount++;
        #2;
        rst_n = 1'b0;
        #1;
        void'(sbQ.pop_front());
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL midshift reset out_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL midshift reset in_ready: got %b expected 1", in_ready); else passCount++;
        checkCount++;
        if (out_data !== 32'h0) $display("[TB] FAIL midshift reset out_data: got %h expected 0", out_data); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        e.data = 32'd3; e.flags = 3'b000; e.lat = 24;
        applyStimulus(32'h40400000, e, acc);
        waitOutput(lat, to);
        e = sbQ.pop_front();
        checkCount++;
        if (!acc || to) $display("[TB] FAIL post-reset handshake: accepted=%b timedOut=%b expected 1/0", acc, to); else passCount++;
        checkCount++;
        if (out_data !== e.data) $display("[TB] FAIL post-reset data: got %h expected %h", out_data, e.data); else passCount++;
        checkCount++;
        if (lat != e.lat) $display("[TB] FAIL post-reset latency: got %0d expected %0d", lat, e.lat); else passCount++;
        takeOutput();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3] = '{32'h42F60000, 32'hC2F70000, 32'h4B000000};
        exp_t e;
        bit   acc, to;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vals[i], model(vals[i]), acc);
            waitOutput(lat, to);
            e = sbQ.pop_front();
            checkCount++;
            if (!acc || to) $display("[TB] FAIL b2b[%0d] handshake: accepted=%b timedOut=%b expected 1/0", i, acc, to); else passCount++;
            checkCount++;
            if (out_data !== e.data) $display("[TB] FAIL b2b[%0d] data: got %h expected %h", i, out_data, e.data); else passCount++;
            checkCount++;
            if (in_ready !== 1'b0) $display("[TB] FAIL b2b[%0d] turnaround in_ready: got %b expected 0", i, in_ready); else passCount++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkCount++;
        if (sbQ.size() != 0) $display("[TB] FAIL scoreboard leftovers: got %0d expected 0", sbQ.size()); else passCount++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midshift();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
